// File: rtl/multiplier_request_controller.sv
// multiplier_request_controller: sequences one 2x2-bit operand request through clamp, flush,
// burn-in and sampling of the p-bit multiplier, then returns product, match and timeout flags.
module multiplier_request_controller #(
    parameter int P = 7,
    parameter int P2 = ((P + 1) / 2) - 1,
    parameter int P3 = ((P + 1) / 4) - 1,
    parameter int BURN_IN = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [P3:0]   req_a,
    input  logic [P3:0]   req_b,
    output logic          clamp_en,
    output logic [P3:0]   clamp_a,
    output logic [P3:0]   clamp_b,
    output logic          interp_rst,
    output logic          pending_request,
    input  logic [P2:0]   interp_result,
    input  logic          interp_valid,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [P2:0]   rsp_product,
    output logic          rsp_match,
    output logic          rsp_timeout,
    output logic [15:0]   err_count
);
    typedef enum logic [2:0] {IDLE, FLUSH, SETTLE, RUN, RESP} state_t;
    localparam int CMAX = BURN_IN > TIMEOUT_CYCLES ? BURN_IN : TIMEOUT_CYCLES;
    localparam int CW = $clog2(CMAX);
    localparam logic [CW-1:0] SETTLE_END = CW'(BURN_IN - 1);
    localparam logic [CW-1:0] RUN_END = CW'(TIMEOUT_CYCLES - 1);
    state_t state, next;
    logic [CW-1:0] cnt;
    logic [P2:0] prod;
    logic hit;
    logic done;
    assign prod = (P2+1)'(clamp_a) * (P2+1)'(clamp_b);
    assign hit = interp_valid && interp_result == prod;
    assign done = state == RUN && next == RESP;
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = req_valid ? FLUSH : IDLE;
            FLUSH:   next = BURN_IN == 0 ? RUN : SETTLE;
            SETTLE:  next = cnt == SETTLE_END ? RUN : SETTLE;
            RUN:     next = interp_valid || cnt == RUN_END ? RESP : RUN;
            RESP:    next = rsp_ready ? IDLE : RESP;
            default: next = IDLE;
        endcase
        req_ready = state == IDLE;
        clamp_en = state != IDLE;
        pending_request = state == RUN;
        rsp_valid = state == RESP;
        interp_rst = RST || state == FLUSH;
    end
    // One shared counter: burn-in length in SETTLE, elapsed sampling cycles in RUN.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt <= '0;
            clamp_a <= '0;
            clamp_b <= '0;
            rsp_product <= '0;
            rsp_match <= 1'b0;
            rsp_timeout <= 1'b0;
            err_count <= '0;
        end else begin
            state <= next;
            cnt <= next != state ? '0 : cnt + CW'(1);
            if (state == IDLE && req_valid) begin
                clamp_a <= req_a;
                clamp_b <= req_b;
            end
            if (done) begin
                rsp_product <= interp_valid ? interp_result : '0;
                rsp_match <= hit;
                rsp_timeout <= !interp_valid;
                if (!hit && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_multiplier_request_controller.sv
// tb_multiplier_request_controller: two controllers (BURN_IN 16/TIMEOUT 64 and BURN_IN 0/TIMEOUT 8) against a request-timeline model.
module tb_multiplier_request_controller;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic pre = 1'b0;
    logic req_valid [2];
    logic req_ready [2];
    logic [1:0] req_a [2];
    logic [1:0] req_b [2];
    logic clamp_en [2];
    logic [1:0] clamp_a [2];
    logic [1:0] clamp_b [2];
    logic interp_rst [2];
    logic pending_request [2];
    logic [3:0] interp_result [2];
    logic interp_valid [2];
    logic rsp_valid [2];
    logic rsp_ready [2];
    logic [3:0] rsp_product [2];
    logic rsp_match [2];
    logic rsp_timeout [2];
    logic [15:0] err_count [2];
    int nchk = 0;
    int nfail = 0;

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 2; g++) begin : u
        multiplier_request_controller #(.BURN_IN(g == 0 ? 16 : 0), .TIMEOUT_CYCLES(g == 0 ? 64 : 8)) dut (
            .CLK(CLK), .RST(RST),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_a(req_a[g]), .req_b(req_b[g]),
            .clamp_en(clamp_en[g]), .clamp_a(clamp_a[g]), .clamp_b(clamp_b[g]),
            .interp_rst(interp_rst[g]), .pending_request(pending_request[g]),
            .interp_result(interp_result[g]), .interp_valid(interp_valid[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_product(rsp_product[g]),
            .rsp_match(rsp_match[g]), .rsp_timeout(rsp_timeout[g]), .err_count(err_count[g])
        );
    end

    function automatic int bi(int g);
        return g == 0 ? 16 : 0;
    endfunction

    function automatic int tmo(int g);
        return g == 0 ? 64 : 8;
    endfunction

    // Model: age counts cycles since acceptance; age 1 is the flush, sampling starts at age BURN_IN+2.
    bit busy [2];
    bit resp [2];
    int age [2];
    logic [1:0] ea [2];
    logic [1:0] eb [2];
    logic [3:0] ep [2];
    bit em [2];
    bit et [2];
    logic [15:0] err_m [2];

    always @(posedge CLK) begin
        for (int g = 0; g < 2; g++) begin
            logic [15:0] e;
            bit ok;
            e = (g == 1 && pre) ? 16'hFFFE : err_m[g];
            ok = interp_valid[g] && int'(interp_result[g]) == int'(ea[g]) * int'(eb[g]);
            if (RST) begin
                busy[g] <= 0; resp[g] <= 0; age[g] <= 0; ea[g] <= 0; eb[g] <= 0;
                ep[g] <= 0; em[g] <= 0; et[g] <= 0; err_m[g] <= 0;
            end else begin
                err_m[g] <= e;
                if (!busy[g]) begin
                    if (req_valid[g]) begin
                        busy[g] <= 1; age[g] <= 1; ea[g] <= req_a[g]; eb[g] <= req_b[g];
                    end
                end else if (resp[g]) begin
                    if (rsp_ready[g]) begin
                        busy[g] <= 0; resp[g] <= 0;
                    end
                end else if (age[g] >= bi(g) + 2 && (interp_valid[g] || age[g] - bi(g) - 2 == tmo(g) - 1)) begin
                    resp[g] <= 1;
                    ep[g] <= interp_valid[g] ? interp_result[g] : 4'd0;
                    em[g] <= ok;
                    et[g] <= !interp_valid[g];
                    if (!ok && e != 16'hFFFF) err_m[g] <= e + 16'd1;
                end else begin
                    age[g] <= age[g] + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int g = 0; g < 2; g++) begin
            bit live;
            live = busy[g] && !resp[g];
            chk($sformatf("u%0d.req_ready", g), 32'(req_ready[g]), 32'(!busy[g]));
            chk($sformatf("u%0d.clamp_en", g), 32'(clamp_en[g]), 32'(busy[g]));
            chk($sformatf("u%0d.clamp_a", g), 32'(clamp_a[g]), 32'(ea[g]));
            chk($sformatf("u%0d.clamp_b", g), 32'(clamp_b[g]), 32'(eb[g]));
            chk($sformatf("u%0d.interp_rst", g), 32'(interp_rst[g]), 32'(RST || (live && age[g] == 1)));
            chk($sformatf("u%0d.pending", g), 32'(pending_request[g]), 32'(live && age[g] >= bi(g) + 2));
            chk($sformatf("u%0d.rsp_valid", g), 32'(rsp_valid[g]), 32'(resp[g]));
            chk($sformatf("u%0d.rsp_product", g), 32'(rsp_product[g]), 32'(ep[g]));
            chk($sformatf("u%0d.rsp_match", g), 32'(rsp_match[g]), 32'(em[g]));
            chk($sformatf("u%0d.rsp_timeout", g), 32'(rsp_timeout[g]), 32'(et[g]));
            chk($sformatf("u%0d.err_count", g), 32'(err_count[g]), 32'(err_m[g]));
        end
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
        compare_all();
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic req(input int g, input int a, input int b);
        req_valid[g] = 1'b1;
        req_a[g] = 2'(a);
        req_b[g] = 2'(b);
        step();
        req_valid[g] = 1'b0;
    endtask

    task automatic pulse(input int g, input int res);
        interp_valid[g] = 1'b1;
        interp_result[g] = 4'(res);
        step();
        interp_valid[g] = 1'b0;
    endtask

    task automatic hs(input int g);
        rsp_ready[g] = 1'b1;
        step();
        rsp_ready[g] = 1'b0;
    endtask

    task automatic wait_rsp(input int g, output int n);
        n = 0;
        while (!rsp_valid[g] && n < 300) begin
            step();
            n++;
        end
        chk("rsp_valid_wait", 32'(rsp_valid[g]), 1);
    endtask

    initial begin
        int n;
        for (int g = 0; g < 2; g++) begin
            req_valid[g] = 0; req_a[g] = 0; req_b[g] = 0;
            interp_valid[g] = 0; interp_result[g] = 0; rsp_ready[g] = 0;
        end
        steps(3);
        RST = 1'b0;
        step();
        chk("reset_req_ready", 32'(req_ready[0]), 1);
        chk("reset_clamp_en", 32'(clamp_en[0]), 0);
        // 2x3 with a stray result pulse during burn-in
        req(0, 2, 3);
        chk("flush_interp_rst", 32'(interp_rst[0]), 1);
        chk("flush_clamp_a", 32'(clamp_a[0]), 2);
        chk("flush_clamp_b", 32'(clamp_b[0]), 3);
        steps(3);
        pulse(0, 6);
        steps(12);
        chk("settle_last_pending", 32'(pending_request[0]), 0);
        step();
        chk("run_first_pending", 32'(pending_request[0]), 1);
        steps(21);
        pulse(0, 6);
        chk("a_rsp_valid", 32'(rsp_valid[0]), 1);
        chk("a_product", 32'(rsp_product[0]), 6);
        chk("a_match", 32'(rsp_match[0]), 1);
        chk("a_timeout", 32'(rsp_timeout[0]), 0);
        chk("a_err", 32'(err_count[0]), 0);
        hs(0);
        chk("a_idle_ready", 32'(req_ready[0]), 1);
        // 3x3 answered with 8
        req(0, 3, 3);
        steps(29);
        pulse(0, 8);
        chk("mm_product", 32'(rsp_product[0]), 8);
        chk("mm_match", 32'(rsp_match[0]), 0);
        chk("mm_err", 32'(err_count[0]), 1);
        hs(0);
        // timeout, then 20 cycles of backpressure with a stray pulse
        req(0, 1, 1);
        wait_rsp(0, n);
        chk("tmo_latency", n, 81);
        chk("tmo_flag", 32'(rsp_timeout[0]), 1);
        chk("tmo_product", 32'(rsp_product[0]), 0);
        chk("tmo_err", 32'(err_count[0]), 2);
        steps(5);
        pulse(0, 1);
        steps(13);
        chk("bp_req_ready", 32'(req_ready[0]), 0);
        chk("bp_timeout_held", 32'(rsp_timeout[0]), 1);
        rsp_ready[0] = 1'b1;
        req_valid[0] = 1'b1;
        req_a[0] = 2'd1;
        req_b[0] = 2'd2;
        step();
        rsp_ready[0] = 1'b0;
        chk("after_hs_ready", 32'(req_ready[0]), 1);
        step();
        req_valid[0] = 1'b0;
        chk("next_req_flush", 32'(interp_rst[0]), 1);
        // result arrives on the last allowed sampling cycle
        steps(80);
        pulse(0, 2);
        chk("coin_timeout", 32'(rsp_timeout[0]), 0);
        chk("coin_product", 32'(rsp_product[0]), 2);
        chk("coin_match", 32'(rsp_match[0]), 1);
        chk("coin_err", 32'(err_count[0]), 2);
        hs(0);
        // BURN_IN=0 instance
        req(1, 3, 2);
        chk("b0_flush", 32'(interp_rst[1]), 1);
        step();
        chk("b0_run_pending", 32'(pending_request[1]), 1);
        pulse(1, 6);
        chk("b0_match", 32'(rsp_match[1]), 1);
        hs(1);
        req(1, 2, 2);
        wait_rsp(1, n);
        chk("b0_tmo_latency", n, 9);
        chk("b0_tmo_err", 32'(err_count[1]), 1);
        hs(1);
        force u[1].dut.err_count = 16'hFFFE;
        release u[1].dut.err_count;
        pre = 1'b1;
        step();
        pre = 1'b0;
        chk("sat_preload", 32'(err_count[1]), 32'hFFFE);
        req(1, 3, 3);
        step();
        pulse(1, 1);
        chk("sat_reach", 32'(err_count[1]), 32'hFFFF);
        hs(1);
        req(1, 1, 1);
        step();
        pulse(1, 0);
        chk("sat_hold", 32'(err_count[1]), 32'hFFFF);
        hs(1);
        // reset while sampling
        req(0, 2, 2);
        steps(29);
        chk("pre_rst_pending", 32'(pending_request[0]), 1);
        RST = 1'b1;
        step();
        chk("rst_interp_rst", 32'(interp_rst[0]), 1);
        chk("rst_req_ready", 32'(req_ready[0]), 1);
        steps(2);
        RST = 1'b0;
        step();
        chk("post_rst_pending", 32'(pending_request[0]), 0);
        chk("post_rst_rsp_valid", 32'(rsp_valid[0]), 0);
        chk("post_rst_err0", 32'(err_count[0]), 0);
        chk("post_rst_err1", 32'(err_count[1]), 0);
        chk("post_rst_interp_rst", 32'(interp_rst[0]), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
